// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Multi-cycle multiply/divide sequencer driving the HI/LO register write port.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, stalls the pipeline while a
// multiply or divide is in flight, then emits a single registered write strobe.
// Multiply: product of the latched operands, released after MUL_CYCLES cycles.
// Divide: radix-2 restoring divider on magnitudes, followed by a sign fixup.
module hilo_muldiv_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Multiply counter starts at MUL_CYCLES-1 and strobes on the cycle it is 0.
  localparam logic [5:0] MUL_INIT = 6'(MUL_CYCLES - 1);
  // The divide state spends one extra cycle at the terminal count before FIX,
  // giving 32 steps + 1 handoff + 1 FIX cycle between acceptance and strobe.
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Two's-complement negate.
  function automatic logic [31:0] f_neg(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a signed 32-bit value; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [31:0] f_abs(input logic [31:0] x);
    return x[31] ? f_neg(x) : x;
  endfunction

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_a;        // raw rs operand (multiplicand, or original dividend)
  logic [31:0] r_b;        // multiplier, or divisor magnitude
  logic        r_signed;   // multiply is signed (MULT)
  logic        r_neg_q;    // quotient must be negated at fixup
  logic        r_neg_r;    // remainder must be negated at fixup
  logic        r_dz;       // divisor was zero
  logic [63:0] r_rq;       // {remainder, quotient} shift register
  logic [1:0]  r_we;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_muldiv;
  logic        w_accept;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_rq_next;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  // Request decode and the combinational pipeline stall.
  always_comb begin
    w_is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    w_accept    = start & ~cancel;
    stall       = (r_state != S_IDLE) | (w_accept & w_is_muldiv);
  end

  // 64-bit product of the latched operands; sign extension selects MULT vs MULTU,
  // and the low 64 bits of the extended product are exact in both cases.
  always_comb begin
    w_ea   = {{32{r_signed & r_a[31]}}, r_a};
    w_eb   = {{32{r_signed & r_b[31]}}, r_b};
    w_prod = w_ea * w_eb;
  end

  // One restoring-division step: shift left, trial-subtract the divisor from the
  // 33-bit partial remainder, keep the difference and shift in a 1 if it fits.
  always_comb begin
    w_rem_sh = r_rq[63:31];
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    w_sub    = w_rem_sh[31:0] - r_b;
    if (w_ge) begin
      w_rq_next = {w_sub, r_rq[30:0], 1'b1};
    end else begin
      w_rq_next = {r_rq[62:0], 1'b0};
    end
  end

  // Sign fixup of quotient/remainder; a zero divisor returns all-ones quotient
  // and the untouched original dividend.
  always_comb begin
    w_q = r_rq[31:0];
    w_r = r_rq[63:32];
    if (r_dz) begin
      w_fix_lo = 32'hFFFF_FFFF;
      w_fix_hi = r_a;
    end else begin
      w_fix_lo = r_neg_q ? f_neg(w_q) : w_q;
      w_fix_hi = r_neg_r ? f_neg(w_r) : w_r;
    end
  end

  // Sequencer FSM with registered write strobe and write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_rq     <= 64'd0;
      r_we     <= 2'b00;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_we <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= (op == OP_MULT);
                r_cnt    <= MUL_INIT;
                r_state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_a      <= a;
                r_signed <= (op == OP_DIV);
                r_dz     <= (b == 32'd0);
                r_cnt    <= 6'd0;
                r_state  <= S_DIV;
                if (op == OP_DIV) begin
                  r_b     <= f_abs(b);
                  r_rq    <= {32'd0, f_abs(a)};
                  r_neg_q <= a[31] ^ b[31];
                  r_neg_r <= a[31];
                end else begin
                  r_b     <= b;
                  r_rq    <= {32'd0, a};
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                end
              end
              OP_MTHI: begin
                r_we <= 2'b10;
                r_hi <= a;
              end
              OP_MTLO: begin
                r_we <= 2'b01;
                r_lo <= a;
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        S_MUL: begin
          // The strobe cycle wins over a simultaneous cancel.
          if (r_cnt == 6'd0) begin
            r_we    <= 2'b11;
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= S_IDLE;
          end else if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DIV: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else if (r_cnt == DIV_LAST) begin
            r_state <= S_FIX;
          end else begin
            r_rq  <= w_rq_next;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIX: begin
          // FIX always registers the strobe, so cancel cannot suppress it here.
          r_we    <= 2'b11;
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hilo_we  = r_we;
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: scoreboard of expected strobes,
// one task per feature, cycle numbering relative to the accepting clock edge.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_LAT    = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        stall;
  logic [1:0]  hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  we;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        req_stall;

  hilo_muldiv_ctrl #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_ITERS (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .stall   (stall),
    .hilo_we (hilo_we),
    .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mul_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (o == 3'd0) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Returns {hi, lo} = {remainder, quotient}.
  function automatic logic [63:0] div_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sx = x;
      sy = y;
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 req_stall = stall;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'd0; b = 32'd0;
  endtask

  task automatic push_exp(input logic [1:0] we, input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t e;
    if (we[1]) m_hi = hi;
    if (we[0]) m_lo = lo;
    e.we = we; e.hi = m_hi; e.lo = m_lo; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Sample on falling edges; k=0 is the cycle right after the accepting edge.
  task automatic wait_strobe(input int limit, output int lat, output logic [1:0] we,
                             output logic [31:0] hi, output logic [31:0] lo,
                             output logic busy_ok, output logic st_at);
    lat = -1; we = 2'b00; hi = 32'd0; lo = 32'd0; busy_ok = 1'b1; st_at = 1'bx;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (hilo_we !== 2'b00) begin
        lat = k; we = hilo_we; hi = hi_wdata; lo = lo_wdata; st_at = stall;
        break;
      end
      if (stall !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd6; a = 32'd0; b = 32'd0; cancel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    total++;
    if (hilo_we !== 2'b00) begin bad++; $display("FAIL reset_we: got %b want 00", hilo_we); end
    total++;
    if (hi_wdata !== 32'd0 || lo_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_wdata: got hi=%h lo=%h want 0/0", hi_wdata, lo_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  ops[4];
    logic [31:0] xs[4], ys[4], ehi[4], elo[4];
    logic [63:0] p;
    int lat; logic [1:0] we; logic [31:0] hi, lo; logic busy_ok, st_at; exp_t e;
    ops[0] = 3'd0; xs[0] = 32'hFFFF_FFFF; ys[0] = 32'h0000_0002; ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFFE;
    ops[1] = 3'd1; xs[1] = 32'hFFFF_FFFF; ys[1] = 32'h0000_0002; ehi[1] = 32'h0000_0001; elo[1] = 32'hFFFF_FFFE;
    for (int i = 2; i < 4; i++) begin
      ops[i] = (i == 2) ? 3'd0 : 3'd1;
      xs[i] = $urandom; ys[i] = $urandom;
      p = mul_model(ops[i], xs[i], ys[i]);
      ehi[i] = p[63:32]; elo[i] = p[31:0];
    end
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i]);
      push_exp(2'b11, ehi[i], elo[i], MUL_CYCLES);
      wait_strobe(20, lat, we, hi, lo, busy_ok, st_at);
      e = exp_q.pop_front();
      total++;
      if (lat !== e.lat) begin bad++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, e.lat); end
      total++;
      if (we !== e.we || hi !== e.hi || lo !== e.lo) begin
        bad++; $display("FAIL mul%0d_result: got we=%b hi=%h lo=%h want we=%b hi=%h lo=%h", i, we, hi, lo, e.we, e.hi, e.lo);
      end
      total++;
      if (req_stall !== 1'b1 || busy_ok !== 1'b1 || st_at !== 1'b0) begin
        bad++; $display("FAIL mul%0d_stall: got req=%b busy=%b at_strobe=%b want 1/1/0", i, req_stall, busy_ok, st_at);
      end
    end
  endtask

  task automatic test_div(input bit corners);
    logic [2:0]  ops[4];
    logic [31:0] xs[4], ys[4], ehi[4], elo[4];
    logic [63:0] r;
    string nm;
    int lat; logic [1:0] we; logic [31:0] hi, lo; logic busy_ok, st_at; exp_t e;
    if (!corners) begin
      ops[0] = 3'd3; xs[0] = 32'd100;        ys[0] = 32'd7;         ehi[0] = 32'd2;         elo[0] = 32'd14;
      ops[1] = 3'd2; xs[1] = 32'hFFFF_FFF9;  ys[1] = 32'd2;         ehi[1] = 32'hFFFF_FFFF; elo[1] = 32'hFFFF_FFFD;
      ops[2] = 3'd2; xs[2] = 32'd7;          ys[2] = 32'hFFFF_FFFE; ehi[2] = 32'd1;         elo[2] = 32'hFFFF_FFFD;
      ops[3] = 3'd2; xs[3] = $urandom;       ys[3] = $urandom_range(1, 5000);
      if ($urandom_range(0, 1) == 1) ys[3] = -ys[3];
      r = div_model(ops[3], xs[3], ys[3]);
      ehi[3] = r[63:32]; elo[3] = r[31:0];
    end else begin
      ops[0] = 3'd2; xs[0] = 32'h1234_5678; ys[0] = 32'd0;         ehi[0] = 32'h1234_5678; elo[0] = 32'hFFFF_FFFF;
      ops[1] = 3'd2; xs[1] = 32'h8765_4321; ys[1] = 32'd0;         ehi[1] = 32'h8765_4321; elo[1] = 32'hFFFF_FFFF;
      ops[2] = 3'd3; xs[2] = 32'hFFFF_FFF0; ys[2] = 32'd0;         ehi[2] = 32'hFFFF_FFF0; elo[2] = 32'hFFFF_FFFF;
      ops[3] = 3'd2; xs[3] = 32'h8000_0000; ys[3] = 32'hFFFF_FFFF; ehi[3] = 32'd0;         elo[3] = 32'h8000_0000;
    end
    for (int i = 0; i < 4; i++) begin
      nm = $sformatf("%s%0d", corners ? "divc" : "div", i);
      issue(ops[i], xs[i], ys[i]);
      push_exp(2'b11, ehi[i], elo[i], DIV_LAT);
      wait_strobe(60, lat, we, hi, lo, busy_ok, st_at);
      e = exp_q.pop_front();
      total++;
      if (lat !== e.lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, e.lat); end
      total++;
      if (we !== e.we || hi !== e.hi || lo !== e.lo) begin
        bad++; $display("FAIL %s_result: got we=%b hi=%h lo=%h want we=%b hi=%h lo=%h", nm, we, hi, lo, e.we, e.hi, e.lo);
      end
      total++;
      if (busy_ok !== 1'b1 || st_at !== 1'b0) begin
        bad++; $display("FAIL %s_stall: got busy=%b at_strobe=%b want 1/0", nm, busy_ok, st_at);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    int lat; logic [1:0] we; logic [31:0] hi, lo; logic busy_ok, st_at; exp_t e;
    int strobes; logic st_seen;
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    push_exp(2'b10, 32'hDEAD_BEEF, 32'd0, 0);
    wait_strobe(5, lat, we, hi, lo, busy_ok, st_at);
    e = exp_q.pop_front();
    total++;
    if (lat !== e.lat || we !== e.we || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL mthi: got lat=%0d we=%b hi=%h lo=%h want lat=%0d we=%b hi=%h lo=%h", lat, we, hi, lo, e.lat, e.we, e.hi, e.lo);
    end
    total++;
    if (req_stall !== 1'b0 || st_at !== 1'b0) begin
      bad++; $display("FAIL mthi_stall: got req=%b strobe_cycle=%b want 0/0", req_stall, st_at);
    end
    // MTHI immediately followed by MTLO.
    push_exp(2'b10, 32'h1111_2222, 32'd0, 0);
    push_exp(2'b01, 32'd0, 32'h3333_4444, 0);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1111_2222;
    @(posedge clk); #1;
    op = 3'd5; a = 32'h3333_4444;
    e = exp_q.pop_front();
    total++;
    if (hilo_we !== e.we || hi_wdata !== e.hi || lo_wdata !== e.lo || stall !== 1'b0) begin
      bad++; $display("FAIL b2b_mthi: got we=%b hi=%h lo=%h stall=%b want we=%b hi=%h lo=%h stall=0", hilo_we, hi_wdata, lo_wdata, stall, e.we, e.hi, e.lo);
    end
    @(posedge clk); #1;
    start = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (hilo_we !== e.we || hi_wdata !== e.hi || lo_wdata !== e.lo) begin
      bad++; $display("FAIL b2b_mtlo: got we=%b hi=%h lo=%h want we=%b hi=%h lo=%h", hilo_we, hi_wdata, lo_wdata, e.we, e.hi, e.lo);
    end
    @(posedge clk); #1;
    total++;
    if (hilo_we !== 2'b00) begin bad++; $display("FAIL mtlo_pulse_width: got %b want 00", hilo_we); end
    // Ops 6 and 7 do nothing.
    strobes = 0; st_seen = 1'b0;
    issue(3'd6, 32'hAAAA_5555, 32'd3);
    st_seen = st_seen | req_stall;
    issue(3'd7, 32'h5555_AAAA, 32'd3);
    st_seen = st_seen | req_stall;
    repeat (6) begin
      @(negedge clk);
      if (hilo_we !== 2'b00) strobes++;
      st_seen = st_seen | stall;
    end
    total++;
    if (strobes !== 0 || st_seen !== 1'b0) begin
      bad++; $display("FAIL op67_ignored: got strobes=%0d stall_seen=%b want 0/0", strobes, st_seen);
    end
  endtask

  task automatic test_cancel();
    int lat; logic [1:0] we; logic [31:0] hi, lo; logic busy_ok, st_at; exp_t e;
    int strobes; logic [63:0] p;
    issue(3'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL cancel_div_idle: got stall=%b want 0", stall); end
    strobes = 0;
    repeat (45) begin
      @(negedge clk);
      if (hilo_we !== 2'b00) strobes++;
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL cancel_div_nostrobe: got %0d strobes want 0", strobes); end
    // A fresh MULTU after the cancel runs normally.
    p = mul_model(3'd1, 32'h0001_0003, 32'h0002_0005);
    issue(3'd1, 32'h0001_0003, 32'h0002_0005);
    push_exp(2'b11, p[63:32], p[31:0], MUL_CYCLES);
    wait_strobe(20, lat, we, hi, lo, busy_ok, st_at);
    e = exp_q.pop_front();
    total++;
    if (lat !== e.lat || we !== e.we || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL cancel_then_multu: got lat=%0d we=%b hi=%h lo=%h want lat=%0d we=%b hi=%h lo=%h", lat, we, hi, lo, e.lat, e.we, e.hi, e.lo);
    end
    // Cancel in the cycle the multiply strobe is registered keeps the strobe.
    p = mul_model(3'd0, 32'hFFFF_FF00, 32'h0000_0123);
    issue(3'd0, 32'hFFFF_FF00, 32'h0000_0123);
    push_exp(2'b11, p[63:32], p[31:0], MUL_CYCLES);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (hilo_we !== e.we || hi_wdata !== e.hi || lo_wdata !== e.lo) begin
      bad++; $display("FAIL cancel_at_strobe: got we=%b hi=%h lo=%h want we=%b hi=%h lo=%h", hilo_we, hi_wdata, lo_wdata, e.we, e.hi, e.lo);
    end
    @(posedge clk); #1;
    total++;
    if (hilo_we !== 2'b00) begin bad++; $display("FAIL strobe_pulse_width: got %b want 00", hilo_we); end
    // start and cancel together: nothing accepted.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9; cancel = 1'b1;
    #1 req_stall = stall;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    total++;
    if (req_stall !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL start_cancel_stall: got req=%b after=%b want 0/0", req_stall, stall);
    end
    strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (hilo_we !== 2'b00) strobes++;
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL start_cancel_nostrobe: got %0d strobes want 0", strobes); end
  endtask

  task automatic test_back_to_back();
    int lat; int strobes; logic [1:0] we; logic [31:0] hi, lo; logic busy_ok, st_at; exp_t e;
    logic [63:0] p;
    // A start while dividing must be ignored.
    issue(3'd3, 32'd1000, 32'd33);
    push_exp(2'b11, 32'd10, 32'd30, DIV_LAT);
    strobes = 0; lat = -1; we = 2'b00; hi = 32'd0; lo = 32'd0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
      end else if (k == 6) begin
        start = 1'b0; op = 3'd6;
      end
      if (hilo_we !== 2'b00) begin
        strobes++;
        if (lat < 0) begin lat = k; we = hilo_we; hi = hi_wdata; lo = lo_wdata; end
      end
    end
    e = exp_q.pop_front();
    total++;
    if (strobes !== 1 || lat !== e.lat) begin
      bad++; $display("FAIL start_in_div: got strobes=%0d lat=%0d want 1/%0d", strobes, lat, e.lat);
    end
    total++;
    if (we !== e.we || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL start_in_div_result: got we=%b hi=%h lo=%h want we=%b hi=%h lo=%h", we, hi, lo, e.we, e.hi, e.lo);
    end
    // New request presented in the very cycle the previous strobe is visible.
    p = mul_model(3'd1, 32'h0000_0010, 32'h0000_0020);
    issue(3'd0, 32'h0000_0003, 32'hFFFF_FFFD);
    push_exp(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF7, MUL_CYCLES);
    wait_strobe(20, lat, we, hi, lo, busy_ok, st_at);
    e = exp_q.pop_front();
    total++;
    if (lat !== e.lat || we !== e.we || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL b2b_first: got lat=%0d we=%b hi=%h lo=%h want lat=%0d we=%b hi=%h lo=%h", lat, we, hi, lo, e.lat, e.we, e.hi, e.lo);
    end
    start = 1'b1; op = 3'd1; a = 32'h0000_0010; b = 32'h0000_0020;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(2'b11, p[63:32], p[31:0], MUL_CYCLES);
    wait_strobe(20, lat, we, hi, lo, busy_ok, st_at);
    e = exp_q.pop_front();
    total++;
    if (lat !== e.lat || we !== e.we || hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL b2b_second: got lat=%0d we=%b hi=%h lo=%h want lat=%0d we=%b hi=%h lo=%h", lat, we, hi, lo, e.lat, e.we, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid_div();
    int strobes; logic st_seen;
    issue(3'd2, 32'hFFFF_FF00, 32'd7);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || hilo_we !== 2'b00 || hi_wdata !== 32'd0 || lo_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_mid_div: got stall=%b we=%b hi=%h lo=%h want 0/00/0/0", stall, hilo_we, hi_wdata, lo_wdata);
    end
    exp_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    strobes = 0; st_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we !== 2'b00) strobes++;
      st_seen = st_seen | stall;
    end
    total++;
    if (strobes !== 0 || st_seen !== 1'b0) begin
      bad++; $display("FAIL reset_no_strobe: got strobes=%0d stall_seen=%b want 0/0", strobes, st_seen);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div(1'b0);
    test_div(1'b1);
    test_mthi_mtlo();
    test_cancel();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that drives the HI/LO register write port. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and latches the operands. It stalls the pipeline while a multiply or divide is in flight, then issues a single write strobe with the HI/LO data. Divide is an iterative radix-2 restoring divider; multiply is a registered product with a configurable wait latency.

Parameters:
MUL_CYCLES, 2, cycles from accepted multiply to HI/LO write strobe; legal 1..8
DIV_ITERS, 32, quotient bits produced one per cycle; fixed for 32-bit operands, not to be overridden

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-high reset
start  input  1  EX-stage request valid for this cycle
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored (no action)
a  input  32  rs operand: dividend / multiplicand / MTHI/MTLO data
b  input  32  rt operand: divisor / multiplier
cancel  input  1  pipeline flush; aborts any operation in flight
stall  output  1  pipeline stall request (combinational)
hilo_we  output  2  HI/LO write enables: [1]=HI, [0]=LO; registered; one-cycle pulse
hi_wdata  output  32  HI write data, registered
lo_wdata  output  32  LO write data, registered

Behaviour:
- Reset is asynchronous, active-high, and applies at any time, including mid-operation. It forces: state=IDLE; hilo_we=0; hi_wdata=0; lo_wdata=0; all counters and operand registers cleared. No write strobe follows reset.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + ~cancel:
  - op 0/1: latch a and b, go to MUL, counter=MUL_CYCLES-1.
  - op 2/3: latch |a| and |b| (signed) or raw a and b (unsigned), plus the sign flags. Go to DIV, iteration counter=0.
  - op 4 (MTHI): no state change. Next cycle hilo_we=2'b10, hi_wdata=a.
  - op 5 (MTLO): no state change. Next cycle hilo_we=2'b01, lo_wdata=a.
  - op 6/7: no action.
- start is ignored outside IDLE. start is also ignored when cancel=1 in the same cycle.
- stall = (state!=IDLE) | (start & ~cancel & op in {0,1,2,3}). stall is 0 in the cycle hilo_we pulses, so the pipeline releases in that cycle.
- MUL:
  - The 64-bit product is computed from the latched operands: signed for op 0, unsigned for op 1.
  - The counter decrements each cycle. When it reaches 0, go to IDLE with hilo_we=2'b11, hi_wdata=product[63:32], lo_wdata=product[31:0].
  - Strobe timing: start accepted at edge T0 -> strobe visible in cycle T0+MUL_CYCLES.
- DIV:
  - Each cycle does one restoring step on the 64-bit {remainder, quotient} shift register.
  - After 32 steps, go to FIX.
  - FIX: negate the quotient if the operand signs differ (signed op only). Negate the remainder if the dividend is negative (signed op only).
  - Then go to IDLE with hilo_we=2'b11, hi_wdata=remainder, lo_wdata=quotient.
  - Strobe timing: start at T0 -> strobe in cycle T0+34.
- Divisor zero (both DIV and DIVU): same 34-cycle latency; result lo=32'hFFFFFFFF, hi=a (the original, unmodified dividend); no sign fixup.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- hilo_we is high for exactly one cycle per completed operation and 0 otherwise. hi_wdata and lo_wdata hold their last values when hilo_we=0.
- cancel in MUL/DIV/FIX: return to IDLE at the next edge with no strobe. Operand registers may be left stale. A cancel in the same cycle a strobe is being registered does not suppress that strobe. cancel in IDLE has no effect.
- The block keeps no HI/LO copy; forwarding is handled downstream.

Test Plan:
- Reset: assert rst asynchronously mid-DIV (cycle 10) -> stall=0, hilo_we=0, both wdata=0 immediately; no strobe afterwards.
- MULT a=0xFFFFFFFF, b=0x00000002 (MUL_CYCLES=2) -> strobe at T0+2, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. stall high in cycles T0 and T0+1, low at T0+2.
- DIVU 100/7 -> strobe at T0+34, lo=14, hi=2. DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- Divide by zero: DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. Overflow DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF -> next cycle hilo_we=2'b10, hi_wdata=0xDEADBEEF, stall never high. MTLO back-to-back -> 2'b01 pulse. start with op=6 -> no strobe.
- cancel at cycle 10 of DIVU -> IDLE next edge, no strobe. A new MULTU issued right after completes normally. A start issued while in DIV is ignored (no extra strobe). start+cancel in the same cycle -> nothing accepted.
